keypad_encode: RTL

Keypad-side encoder for the on-screen character control path. It scans a 4x4 active-low matrix keypad, synchronises and debounces the column returns, and emits each accepted key press as a single-cycle 4-bit command code. That code feeds the input decoder's `inCode`. Every code is presented for exactly one clock per physical press, because the downstream decoder acts on every cycle a code is held (for example, size increments). At all other times the output holds the idle code 4'hF.

---
 rtl/keypad_encode_pkg.sv | 45 ++++
 rtl/keypad_encode_scan_tick.sv | 29 ++
 rtl/keypad_encode.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/keypad_encode_pkg.sv
// Shared constants, key-index map and FSM encoding for the keypad encoder.
// Key indices are row*4 + col and line up with the decoder's command map.
package keypad_encode_pkg;

  localparam logic [3:0] IDLE_CODE    = 4'hF;
  localparam logic [3:0] RESERVED_IDX = 4'hF;

  localparam logic [3:0] KEY_IDX_0  = 4'd0;
  localparam logic [3:0] KEY_IDX_1  = 4'd1;
  localparam logic [3:0] KEY_IDX_2  = 4'd2;
  localparam logic [3:0] KEY_IDX_3  = 4'd3;
  localparam logic [3:0] KEY_IDX_4  = 4'd4;
  localparam logic [3:0] KEY_IDX_5  = 4'd5;
  localparam logic [3:0] KEY_IDX_6  = 4'd6;
  localparam logic [3:0] KEY_IDX_7  = 4'd7;
  localparam logic [3:0] KEY_IDX_8  = 4'd8;
  localparam logic [3:0] KEY_IDX_9  = 4'd9;
  localparam logic [3:0] KEY_IDX_10 = 4'd10;
  localparam logic [3:0] KEY_IDX_11 = 4'd11;
  localparam logic [3:0] KEY_IDX_12 = 4'd12;
  localparam logic [3:0] KEY_IDX_13 = 4'd13;
  localparam logic [3:0] KEY_IDX_14 = 4'd14;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_EMIT     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  // Lowest-index low column; col0 wins when several are pressed.
  function automatic logic [1:0] lowest_low(input logic [3:0] col);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_encode_scan_tick.sv
// Free-running 0..DIV-1 divider; tick_o is high during the cycle the count equals DIV-1.
module scan_tick #(
  parameter int unsigned DIV = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  assign cnt_d  = (cnt_q == CW'(DIV - 1)) ? '0 : cnt_q + CW'(1);
  assign tick_o = tick_q;

  // Tick is registered alongside the count so it flags the wrap cycle exactly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CW'(DIV - 1));
    end
  end

endmodule

// File: rtl/keypad_encode.sv
// 4x4 active-low keypad scanner: synchronise, debounce and emit one-cycle command codes.
// Codes are held for exactly one clock because the decoder acts on every held cycle.
module keypad_encode
  import keypad_encode_pkg::*;
#(
  parameter int unsigned DIV = 1000,
  parameter int unsigned DEB = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] colIn,
  output logic [3:0] rowOut,
  output logic [3:0] inCode,
  output logic       codeStrobe,
  output logic       keyHeld
);

  localparam int unsigned CW = $clog2(DEB + 1);

  state_e        state_q, state_d;
  logic [3:0]    col_meta_q, col_s_q;
  logic [1:0]    row_q, row_d;
  logic [1:0]    col_q, col_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0] rcnt_q, rcnt_d, rcnt_inc;
  logic [3:0]    code_q, code_d;
  logic          strobe_q, strobe_d;
  logic          held_q, held_d;
  logic          tick;
  logic [1:0]    hit_col, emit_col;
  logic [3:0]    emit_idx;

  scan_tick #(.DIV(DIV)) u_scan_tick (
    .clk_i  (clock),
    .rst_i  (reset),
    .tick_o (tick)
  );

  assign hit_col  = lowest_low(col_s_q);
  assign emit_col = (state_q == ST_SCAN) ? hit_col : col_q;
  assign emit_idx = key_index(row_q, emit_col);
  assign cnt_inc  = cnt_q + CW'(1);
  assign rcnt_inc = rcnt_q + CW'(1);

  assign rowOut     = ~(4'b0001 << row_q);
  assign inCode     = code_q;
  assign codeStrobe = strobe_q;
  assign keyHeld    = held_q;

  // Synchroniser idles high so reset looks like "no key".
  always_ff @(posedge clock) begin
    if (reset) begin
      col_meta_q <= 4'hF;
      col_s_q    <= 4'hF;
    end else begin
      col_meta_q <= colIn;
      col_s_q    <= col_meta_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_SCAN;
      row_q    <= 2'd0;
      col_q    <= 2'd0;
      cnt_q    <= '0;
      rcnt_q   <= '0;
      code_q   <= IDLE_CODE;
      strobe_q <= 1'b0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      rcnt_q   <= rcnt_d;
      code_q   <= code_d;
      strobe_q <= strobe_d;
      held_q   <= held_d;
    end
  end

  // Output registers are loaded on entry to EMIT so the code appears in the EMIT cycle.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    cnt_d    = cnt_q;
    rcnt_d   = rcnt_q;
    code_d   = IDLE_CODE;
    strobe_d = 1'b0;
    held_d   = held_q;

    unique case (state_q)
      ST_SCAN: begin
        if (tick) begin
          if (col_s_q == 4'hF) begin
            row_d = row_q + 2'd1;
          end else begin
            col_d = hit_col;
            cnt_d = CW'(1);
            if (DEB == 1) begin
              state_d = ST_EMIT;
              held_d  = 1'b1;
              if (emit_idx != RESERVED_IDX) begin
                code_d   = emit_idx;
                strobe_d = 1'b1;
              end
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end
        end
      end
      ST_DEBOUNCE: begin
        if (tick) begin
          if (!col_s_q[col_q]) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(DEB)) begin
              state_d = ST_EMIT;
              held_d  = 1'b1;
              if (emit_idx != RESERVED_IDX) begin
                code_d   = emit_idx;
                strobe_d = 1'b1;
              end
            end
          end else begin
            state_d = ST_SCAN;
          end
        end
      end
      ST_EMIT: begin
        state_d = ST_RELEASE;
        rcnt_d  = '0;
      end
      ST_RELEASE: begin
        if (tick) begin
          if (col_s_q[col_q]) begin
            rcnt_d = rcnt_inc;
            if (rcnt_inc == CW'(DEB)) begin
              held_d  = 1'b0;
              row_d   = row_q + 2'd1;
              state_d = ST_SCAN;
            end
          end else begin
            rcnt_d = '0;
          end
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

endmodule
